// File: rtl/inv_key_expansion.sv
// ---------------------------------------------------------------------------
// inv_key_expansion
//   Walks the AES-128 key schedule backwards. Starting from the final round
//   key k10 it emits one round key per cycle (k10, k9, ... k0) and finally
//   presents the recovered cipher key k0 on key_out.
//
// Ports
//   clk       : rising-edge clock
//   reset     : synchronous, active-low reset
//   start     : begin a backward schedule from last_key (ignored while busy)
//   last_key  : final round key k10, bits [127:96] hold word W0
//   busy      : schedule in progress
//   rk_valid  : rk / round_idx carry a valid round key this cycle
//   rk        : current round key, same word ordering as last_key
//   round_idx : round number of rk, 10 down to 0
//   done      : one-cycle pulse while k0 is on rk
//   key_out   : recovered cipher key k0, held until the next accepted start
// ---------------------------------------------------------------------------
module inv_key_expansion #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] last_key,
  output logic         busy,
  output logic         rk_valid,
  output logic [127:0] rk,
  output logic [3:0]   round_idx,
  output logic         done,
  output logic [127:0] key_out
);

  generate
    if (NR != 10) begin : g_nr_check
      $error("inv_key_expansion: only NR = 10 (AES-128) is supported");
    end
  endgenerate

  // Forward AES S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t       r_state;
  logic [127:0] r_key;
  logic [3:0]   r_idx;
  logic         r_busy;
  logic         r_valid;
  logic         r_done;
  logic [127:0] r_key_out;
  logic [127:0] w_prev_key;

  // Byte b lives at bit offset (255 - b) * 8, i.e. {~b, 3'b000}.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] rcon(input logic [3:0] j);
    logic [7:0] c;
    case (j)
      4'd1:    c = 8'h01;
      4'd2:    c = 8'h02;
      4'd3:    c = 8'h04;
      4'd4:    c = 8'h08;
      4'd5:    c = 8'h10;
      4'd6:    c = 8'h20;
      4'd7:    c = 8'h40;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h1b;
      4'd10:   c = 8'h36;
      default: c = 8'h00;
    endcase
    return {c, 24'h000000};
  endfunction

  // Undo one forward expansion step. The last three words fall out of the
  // XOR chain directly; P3 is then available to rebuild the g() term that
  // produced W0 in the forward direction.
  function automatic logic [127:0] prev_round_key(input logic [127:0] k,
                                                  input logic [3:0]   j);
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] p0, p1, p2, p3;
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    p3 = w3 ^ w2;
    p2 = w2 ^ w1;
    p1 = w1 ^ w0;
    p0 = w0 ^ sub_word(rot_word(p3)) ^ rcon(j);
    return {p0, p1, p2, p3};
  endfunction

  always_comb begin
    w_prev_key = prev_round_key(r_key, r_idx);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_key     <= '0;
      r_idx     <= '0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
      r_key_out <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_key   <= last_key;
            r_idx   <= 4'd10;
            r_busy  <= 1'b1;
            r_valid <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (r_idx != 4'd0) begin
            r_key <= w_prev_key;
            r_idx <= r_idx - 4'd1;
            // k0 is being loaded: raise done and publish key_out together
            // so both are visible in the same cycle as round_idx = 0.
            if (r_idx == 4'd1) begin
              r_done    <= 1'b1;
              r_key_out <= w_prev_key;
            end
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign rk_valid  = r_valid;
  assign rk        = r_key;
  assign round_idx = r_idx;
  assign done      = r_done;
  assign key_out   = r_key_out;

endmodule

// File: tb/tb_inv_key_expansion.sv
module tb_inv_key_expansion;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [127:0] last_key;
  logic         busy;
  logic         rk_valid;
  logic [127:0] rk;
  logic [3:0]   round_idx;
  logic         done;
  logic [127:0] key_out;

  int total = 0;
  int bad   = 0;
  int n_done = 0;

  always #5 clk = ~clk;

  inv_key_expansion #(.NR(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .last_key  (last_key),
    .busy      (busy),
    .rk_valid  (rk_valid),
    .rk        (rk),
    .round_idx (round_idx),
    .done      (done),
    .key_out   (key_out)
  );

  // ---------------- reference arithmetic (GF(2^8) based) ----------------
  logic [7:0] sb [256];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xtime(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    if (x != 8'h00)
      for (int c = 1; c < 256; c++)
        if (gf_mul(x, 8'(c)) == 8'h01) inv = 8'(c);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon_ref(input int j);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 1; i < j; i++) r = xtime(r);
    return r;
  endfunction

  // Forward AES-128 key expansion; returns round key r of cipher key k0.
  function automatic logic [127:0] fwd_rk(input logic [127:0] k0, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    w[0] = k0[127:96]; w[1] = k0[95:64]; w[2] = k0[63:32]; w[3] = k0[31:0];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t = t ^ {rcon_ref(i / 4), 24'h000000};
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [127:0] cur_k0;
  logic [127:0] m_rks [11];
  logic         m_init  = 1'b0;
  logic         m_busy  = 1'b0;
  logic         m_valid = 1'b0;
  logic         m_done  = 1'b0;
  int           m_idx   = 0;
  logic [127:0] m_rk     = '0;
  logic [127:0] m_keyout = '0;

  always @(posedge clk) begin
    m_init <= 1'b1;
    if (!reset) begin
      m_busy <= 1'b0; m_valid <= 1'b0; m_done <= 1'b0;
      m_idx <= 0; m_rk <= '0; m_keyout <= '0;
    end else if (!m_busy) begin
      m_done <= 1'b0;
      if (start) begin
        for (int r = 0; r <= 10; r++) m_rks[r] = fwd_rk(cur_k0, r);
        m_busy <= 1'b1; m_valid <= 1'b1; m_idx <= 10; m_rk <= m_rks[10];
      end
    end else if (m_idx > 0) begin
      m_idx  <= m_idx - 1;
      m_rk   <= m_rks[m_idx-1];
      m_done <= (m_idx == 1);
      if (m_idx == 1) m_keyout <= m_rks[0];
    end else begin
      m_busy <= 1'b0; m_valid <= 1'b0; m_done <= 1'b0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_init) begin
      check("busy",      128'(busy),      128'(m_busy));
      check("rk_valid",  128'(rk_valid),  128'(m_valid));
      check("done",      128'(done),      128'(m_done));
      check("round_idx", 128'(round_idx), 128'(m_idx));
      check("rk",        rk,              m_rk);
      check("key_out",   key_out,         m_keyout);
    end
    if (done) n_done++;
  end

  // ---------------- stimulus ----------------
  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic run_sched(input logic [127:0] k0);
    cur_k0   = k0;
    last_key = fwd_rk(k0, 10);
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
  endtask

  initial begin
    logic [127:0] k0;
    for (int i = 0; i < 256; i++) sb[i] = sbox_ref(8'(i));

    reset = 1'b0; start = 1'b0; last_key = '0; cur_k0 = '0;

    // Hand-computed values pinning the reference model.
    check("model_sbox00", 128'(sb[0]),  128'h63);
    check("model_sbox53", 128'(sb[83]), 128'hed);
    check("model_k10_a", fwd_rk(128'h000102030405060708090a0b0c0d0e0f, 10),
          128'h13111d7fe3944a17f307a78b4d2b30c5);
    check("model_k9_a",  fwd_rk(128'h000102030405060708090a0b0c0d0e0f, 9),
          128'h549932d1f08557681093ed9cbe2c974e);
    check("model_k10_b", fwd_rk(128'h2b7e151628aed2a6abf7158809cf4f3c, 10),
          128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Known vector 1, with literal DUT expectations.
    cur_k0   = 128'h000102030405060708090a0b0c0d0e0f;
    last_key = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("v1_rk10", rk, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    @(negedge clk);
    check("v1_idx9", 128'(round_idx), 128'd9);
    check("v1_rk9",  rk, 128'h549932d1f08557681093ed9cbe2c974e);
    repeat (9) @(negedge clk);
    check("v1_done",    128'(done), 128'd1);
    check("v1_key_out", key_out, 128'h000102030405060708090a0b0c0d0e0f);
    @(negedge clk);

    // Known vector 2.
    cur_k0   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    last_key = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    check("v2_key_out", key_out, 128'h2b7e151628aed2a6abf7158809cf4f3c);

    // Restart request and last_key change mid-schedule must be ignored.
    n_done = 0;
    cur_k0 = rand128();
    last_key = fwd_rk(cur_k0, 10);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_idx5", 128'(round_idx), 128'd5);
    start = 1'b1; last_key = rand128();
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_one_done", 128'(n_done), 128'd1);

    // Reset mid-schedule, asserted together with start.
    k0 = rand128();
    cur_k0 = k0; last_key = fwd_rk(k0, 10);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_at_idx6", 128'(round_idx), 128'd6);
    reset = 1'b0; start = 1'b1;
    @(negedge clk);
    check("rst_busy",    128'(busy), 128'd0);
    check("rst_rk",      rk, 128'd0);
    check("rst_idx",     128'(round_idx), 128'd0);
    check("rst_key_out", key_out, 128'd0);
    reset = 1'b1; start = 1'b0;
    @(negedge clk);
    run_sched(k0);
    check("post_rst_key_out", key_out, k0);

    // start held high: three back-to-back passes.
    n_done = 0;
    cur_k0 = rand128();
    last_key = fwd_rk(cur_k0, 10);
    start = 1'b1;
    repeat (36) @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    check("b2b_done_count", 128'(n_done), 128'd3);
    check("b2b_key_out", key_out, cur_k0);

    // Random keys against the forward expansion.
    for (int n = 0; n < 6; n++) begin
      k0 = rand128();
      run_sched(k0);
      check("rand_key_out", key_out, k0);
      if (($urandom & 1) == 1) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
